hps_ext_master: RTL and testbench
=================================

// Module: hps_ext_master
// PURPOSE
//  FPGA-side initiator for the HPS extension bus: drives io_enable/io_strobe/io_din and collects io_dout/io_dout_en.
//  Runs one framed transaction per accepted command: a command word followed by 0..15 data words.
//  Bench master for the Archie responder, and on-chip sequencer for self-test and boot replay.
//  Response words are returned one strobe late: the word read at strobe k was produced by strobe k-1.
// PARAMETERS
//  SETUP_CYC  2  cycles io_enable is high before the first strobe (min 1)
//  GAP_CYC    1  low cycles between strobes (min 1)
//  TAIL_CYC   2  cycles io_enable is held low after a frame before cmd_ready rises (min 1)
// PORTS
//  clk_sys      in   1   system clock; all logic on the rising edge
//  reset        in   1   asynchronous, active-high reset
//  cmd_valid    in   1   command request
//  cmd_ready    out  1   high in IDLE only
//  cmd_code     in   8   command word; sent zero-extended as io_din[15:0]
//  cmd_len      in   4   number of data words after the command word (0..15)
//  abort        in   1   end the frame now
//  wdata        in   16  next data word
//  wdata_valid  in   1   wdata is valid
//  wdata_ready  out  1   master takes wdata at this edge
//  rdata        out  16  sampled response word
//  rdata_valid  out  1   one-cycle pulse per response word
//  done         out  1   one-cycle pulse at frame end
//  unsup        out  1   io_dout_en was low when sampled at strobe 1; held until next accept
//  aborted      out  1   last frame ended by abort; held until next accept
//  io_enable    out  1   frame enable to responder
//  io_strobe    out  1   one-cycle word strobe
//  io_din       out  16  word to responder
//  io_dout      in   16  responder data
//  io_dout_en   in   1   responder claims the command
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, cmd_ready=1; every other output 0
//   - reset asserted mid-frame drops io_enable asynchronously, discards the frame, no done pulse
//  States: IDLE -> SETUP -> STROBE -> GAP -> (STROBE | TAIL) -> IDLE
//  IDLE:
//   - cmd_valid&cmd_ready at edge E: latch code/len, clear unsup/aborted, enter SETUP
//   - io_enable=1 from E+1
//  SETUP: after SETUP_CYC cycles of io_enable, enter STROBE.
//  STROBE:
//   - io_strobe=1 for exactly one cycle; idx counts 0..len
//   - idx 0 sends cmd_code; idx>=1 sends the word latched at the wdata_ready&wdata_valid edge
//   - wdata_ready=1 only in the last GAP cycle before a data strobe
//   - wdata_valid low there stalls in GAP with io_enable and io_strobe held; no timeout
//  Sampling, at each strobe with idx>=1:
//   - rdata <= io_dout (value before the strobe); rdata_valid pulses next cycle
//   - exactly len rdata pulses per frame; the response to the final strobe is not returned
//   - at idx==1, unsup <= ~io_dout_en
//  GAP:
//   - io_strobe=0 for at least GAP_CYC cycles
//   - if idx==len, enter TAIL after GAP_CYC cycles
//  TAIL:
//   - io_enable=0, io_din=0
//   - after TAIL_CYC cycles: done pulses and the state returns to IDLE in the same edge, so cmd_ready=1 next cycle
//  Abort (sampled in SETUP, STROBE or GAP):
//   - next cycle io_enable=0 and io_strobe=0; no further wdata_ready or rdata_valid
//   - aborted=1, enter TAIL, then done as normal; abort in IDLE or TAIL is ignored
//  Frame length:
//   - len=0 gives one strobe, no rdata, and leaves unsup unchanged
//   - idx is 4 bits and saturates at 15; it cannot wrap
//  io_din holds its last value between strobes within a frame.
// TESTING
//  - cmd 0x63, len 1, ide_req=6'h05 -> strobes 0x0063 then wdata; one rdata=0xE005; unsup=0; done.
//  - cmd 0x04, len 2, kbd byte 0x5A pending -> rdata 0x00A1 then 0x005A; frame is 3 strobes, each GAP_CYC apart.
//  - cmd 0x61, len 3, wdata_valid withheld 10 cycles before word 2 -> io_enable stays high, no strobe until valid, 4 strobes total.
//  - cmd 0x10, len 1 -> io_dout_en=0 at strobe 1 -> unsup=1, rdata=0x0000, done.
//  - abort during GAP after strobe 1 of a len-5 frame -> io_enable low next cycle, aborted=1, one rdata, done after TAIL_CYC.
//  - reset mid-frame -> io_enable=0 immediately; after release cmd_ready=1 and a new 0x63 frame completes correctly.

Source files
------------

// File: rtl/hps_ext_master.sv
// rtl/hps_ext_master.sv - framed initiator for the HPS extension bus
module hps_ext_master #(
    parameter int SETUP_CYC = 2,
    parameter int GAP_CYC   = 1,
    parameter int TAIL_CYC  = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_code,
    input  logic [3:0]  cmd_len,
    input  logic        abort,
    // write data side
    input  logic [15:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    // response side
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        unsup,
    output logic        aborted,
    // extension bus
    output logic        io_enable,
    output logic        io_strobe,
    output logic [15:0] io_din,
    input  logic [15:0] io_dout,
    input  logic        io_dout_en
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_GAP    = 3'd3,
        S_TAIL   = 3'd4
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
    localparam logic [7:0] TAIL_LAST  = 8'(TAIL_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  code_q;
    logic [3:0]  len_q;
    logic [3:0]  idx_q;
    logic [15:0] din_q;
    logic [15:0] rdata_q;
    logic        rdata_valid_q;
    logic        done_q;
    logic        unsup_q;
    logic        aborted_q;

    logic        accept;
    logic        in_frame;
    logic        gap_done;
    logic        last_word;
    logic        take;
    logic        wdata_ready_c;

    assign accept    = (state_q == S_IDLE) && cmd_valid;
    assign in_frame  = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_GAP);
    assign gap_done  = (cnt_q >= GAP_LAST);
    assign last_word = (idx_q == len_q);
    // A data word is consumed exactly on the GAP -> STROBE transition
    assign take      = wdata_ready_c && wdata_valid;

    // State register; reset drops io_enable immediately because outputs decode state_q
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over every in-frame transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (abort) begin
                    state_d = S_TAIL;
                end else if (cnt_q == SETUP_LAST) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (abort) begin
                    state_d = S_TAIL;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_TAIL;
                end else if (gap_done) begin
                    if (last_word) begin
                        state_d = S_TAIL;
                    end else if (wdata_valid) begin
                        state_d = S_STROBE;
                    end
                end
            end
            S_TAIL: begin
                if (cnt_q == TAIL_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; io_din is forced to zero whenever the frame is not enabled
    always_comb begin
        cmd_ready     = 1'b0;
        io_enable     = 1'b0;
        io_strobe     = 1'b0;
        io_din        = 16'h0000;
        wdata_ready_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_SETUP: begin
                io_enable = 1'b1;
                io_din    = din_q;
            end
            S_STROBE: begin
                io_enable = 1'b1;
                io_strobe = 1'b1;
                io_din    = din_q;
            end
            S_GAP: begin
                io_enable     = 1'b1;
                io_din        = din_q;
                wdata_ready_c = gap_done && !last_word && !abort;
            end
            S_TAIL: begin
                io_enable = 1'b0;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign wdata_ready = wdata_ready_c;

    // Per-state cycle counter: restarts on every state change, saturates during a GAP stall
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'h00;
        end else if (state_d != state_q) begin
            cnt_q <= 8'h00;
        end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'h01;
        end
    end

    // Frame context: command latch, word index and the word presented on io_din
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            code_q <= 8'h00;
            len_q  <= 4'h0;
            idx_q  <= 4'h0;
            din_q  <= 16'h0000;
        end else begin
            if (accept) begin
                code_q <= cmd_code;
                len_q  <= cmd_len;
                idx_q  <= 4'h0;
                din_q  <= 16'h0000;
            end else if ((state_q == S_SETUP) && (state_d == S_STROBE)) begin
                din_q <= {8'h00, code_q};
            end else if (take) begin
                din_q <= wdata;
                if (idx_q != 4'hF) begin
                    idx_q <= idx_q + 4'h1;
                end
            end
        end
    end

    // Response capture: io_dout seen during strobe k is the reply to strobe k-1
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rdata_q       <= 16'h0000;
            rdata_valid_q <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            if ((state_q == S_STROBE) && (idx_q != 4'h0) && !abort) begin
                rdata_q       <= io_dout;
                rdata_valid_q <= 1'b1;
            end
        end
    end

    // Frame status flags, cleared on accept and held until the next one
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            unsup_q   <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_TAIL) && (state_d == S_IDLE);
            if (accept) begin
                unsup_q   <= 1'b0;
                aborted_q <= 1'b0;
            end else begin
                if ((state_q == S_STROBE) && (idx_q == 4'h1) && !abort) begin
                    unsup_q <= ~io_dout_en;
                end
                if (in_frame && abort) begin
                    aborted_q <= 1'b1;
                end
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign unsup       = unsup_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_hps_ext_master.sv
// tb/tb_hps_ext_master.sv - directed self-checking bench for hps_ext_master
module tb_hps_ext_master;

    logic        clk_sys;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_code;
    logic [3:0]  cmd_len;
    logic        abort;
    logic [15:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        unsup;
    logic        aborted;
    logic        io_enable;
    logic        io_strobe;
    logic [15:0] io_din;
    logic [15:0] io_dout;
    logic        io_dout_en;

    hps_ext_master #(
        .SETUP_CYC(2),
        .GAP_CYC  (1),
        .TAIL_CYC (2)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_code   (cmd_code),
        .cmd_len    (cmd_len),
        .abort      (abort),
        .wdata      (wdata),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .done       (done),
        .unsup      (unsup),
        .aborted    (aborted),
        .io_enable  (io_enable),
        .io_strobe  (io_strobe),
        .io_din     (io_din),
        .io_dout    (io_dout),
        .io_dout_en (io_dout_en)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks;
    int failures;

    int cyc;
    int ns;
    int nr;
    int ndone;
    int nhs;
    int wptr;
    int sidx;
    int en_cyc;
    int en_last;
    int accept_cyc;
    int done_cyc;
    int stall_word;
    int stall_left;
    int abort_after;
    logic ready_at_done;
    logic unsup_at_done;
    logic aborted_at_done;

    int          st_cyc [16];
    logic [15:0] st_din [16];
    logic [15:0] rd     [16];
    logic [15:0] wtab   [16];
    logic [15:0] resp_d [16];
    logic        resp_e [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, update responder and sources after the rising edge
    task automatic tick();
        logic hs;
        logic st;
        logic acc;
        @(negedge clk_sys);
        cyc++;
        hs  = wdata_ready && wdata_valid;
        st  = io_strobe;
        acc = cmd_valid && cmd_ready;
        if (acc) accept_cyc = cyc;
        if (hs) nhs++;
        if (io_enable) begin
            en_cyc++;
            en_last = cyc;
        end
        if (io_strobe) begin
            if (ns < 16) begin
                st_cyc[ns] = cyc;
                st_din[ns] = io_din;
            end
            ns++;
        end
        if (rdata_valid) begin
            if (nr < 16) rd[nr] = rdata;
            nr++;
        end
        if (done) begin
            ndone++;
            done_cyc        = cyc;
            ready_at_done   = cmd_ready;
            unsup_at_done   = unsup;
            aborted_at_done = aborted;
        end
        @(posedge clk_sys);
        #1;
        if (acc) cmd_valid = 1'b0;
        if (st) begin
            if (sidx < 16) begin
                io_dout    = resp_d[sidx];
                io_dout_en = resp_e[sidx];
            end
            sidx++;
        end
        if (st && (ns == abort_after)) abort = 1'b1;
        else abort = 1'b0;
        if (hs) begin
            wptr++;
            if (wptr < 16) wdata = wtab[wptr];
            if (wptr == stall_word) begin
                wdata_valid = 1'b0;
                stall_left  = 10;
            end
        end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) wdata_valid = 1'b1;
        end
    endtask

    task automatic new_frame();
        ns = 0; nr = 0; ndone = 0; nhs = 0; wptr = 0; sidx = 0;
        en_cyc = 0; en_last = -1; accept_cyc = -1; done_cyc = -1;
        stall_word = -1; stall_left = 0; abort_after = 0;
        wdata_valid = 1'b1; io_dout = 16'h0000; io_dout_en = 1'b0; abort = 1'b0;
        for (int k = 0; k < 16; k++) begin
            wtab[k]   = 16'hA000 + 16'(k);
            resp_d[k] = 16'h0100 + 16'(k);
            resp_e[k] = 1'b1;
        end
    endtask

    task automatic start_frame(input logic [7:0] code, input logic [3:0] len);
        wdata     = wtab[0];
        cmd_code  = code;
        cmd_len   = len;
        cmd_valid = 1'b1;
    endtask

    task automatic finish_frame();
        for (int i = 0; i < 300 && ndone == 0; i++) tick();
        tick();
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_code = 8'h00; cmd_len = 4'h0;
        new_frame();
        wdata = 16'h0000;
        tick(); tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_io_enable", io_enable, 0);
        chk("rst_io_strobe", io_strobe, 0);
        chk("rst_io_din", io_din, 0);
        chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_rdata_valid", rdata_valid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_done", done, 0);
        chk("rst_unsup", unsup, 0);
        chk("rst_aborted", aborted, 0);

        // cmd 0x63 len 1
        new_frame();
        wtab[0] = 16'h1234; resp_d[0] = 16'hE005;
        start_frame(8'h63, 4'd1);
        finish_frame();
        chk("f1_strobes", ns, 2);
        chk("f1_din0", st_din[0], 16'h0063);
        chk("f1_din1", st_din[1], 16'h1234);
        chk("f1_setup_lat", st_cyc[0] - accept_cyc, 3);
        chk("f1_nrdata", nr, 1);
        chk("f1_rdata0", rd[0], 16'hE005);
        chk("f1_unsup", unsup_at_done, 0);
        chk("f1_done_cnt", ndone, 1);
        chk("f1_done_lat", done_cyc - st_cyc[1], 4);
        chk("f1_ready_at_done", ready_at_done, 1);
        chk("f1_en_cycles", en_cyc, 6);

        // cmd 0x04 len 2
        new_frame();
        resp_d[0] = 16'h00A1; resp_d[1] = 16'h005A;
        start_frame(8'h04, 4'd2);
        finish_frame();
        chk("f2_strobes", ns, 3);
        chk("f2_nrdata", nr, 2);
        chk("f2_rdata0", rd[0], 16'h00A1);
        chk("f2_rdata1", rd[1], 16'h005A);
        chk("f2_space01", st_cyc[1] - st_cyc[0], 2);
        chk("f2_space12", st_cyc[2] - st_cyc[1], 2);
        chk("f2_din2", st_din[2], 16'hA001);

        // cmd 0x61 len 3 with wdata_valid withheld before word 2
        new_frame();
        stall_word = 1;
        start_frame(8'h61, 4'd3);
        finish_frame();
        chk("f3_strobes", ns, 4);
        chk("f3_stall_space", st_cyc[2] - st_cyc[1], 11);
        chk("f3_en_cycles", en_cyc, 19);
        chk("f3_din2", st_din[2], 16'hA001);
        chk("f3_din3", st_din[3], 16'hA002);
        chk("f3_nrdata", nr, 3);
        chk("f3_rdata2", rd[2], 16'h0102);
        chk("f3_done_cnt", ndone, 1);

        // cmd 0x10 len 1, responder does not claim
        new_frame();
        resp_d[0] = 16'h0000; resp_e[0] = 1'b0;
        start_frame(8'h10, 4'd1);
        finish_frame();
        chk("f4_unsup", unsup_at_done, 1);
        chk("f4_unsup_held", unsup, 1);
        chk("f4_rdata0", rd[0], 16'h0000);
        chk("f4_nrdata", nr, 1);
        chk("f4_done_cnt", ndone, 1);

        // len 0: single strobe, no response, flag cleared by accept
        new_frame();
        start_frame(8'h20, 4'd0);
        finish_frame();
        chk("f5_strobes", ns, 1);
        chk("f5_nrdata", nr, 0);
        chk("f5_unsup", unsup_at_done, 0);
        chk("f5_en_cycles", en_cyc, 4);
        chk("f5_done_lat", done_cyc - st_cyc[0], 4);

        // len 15: index reaches its top value
        new_frame();
        start_frame(8'h30, 4'd15);
        finish_frame();
        chk("f6_strobes", ns, 16);
        chk("f6_nrdata", nr, 15);
        chk("f6_rdata0", rd[0], 16'h0100);
        chk("f6_rdata14", rd[14], 16'h010E);
        chk("f6_din15", st_din[15], 16'hA00E);
        chk("f6_done_cnt", ndone, 1);

        // abort in GAP after strobe 1 of a len-5 frame
        new_frame();
        abort_after = 2;
        start_frame(8'h40, 4'd5);
        finish_frame();
        chk("f7_strobes", ns, 2);
        chk("f7_nrdata", nr, 1);
        chk("f7_takes", nhs, 1);
        chk("f7_en_drop", en_last - st_cyc[1], 1);
        chk("f7_aborted", aborted_at_done, 1);
        chk("f7_done_cnt", ndone, 1);
        chk("f7_done_lat", done_cyc - st_cyc[1], 4);

        // abort while idle is ignored
        abort = 1'b1;
        @(negedge clk_sys);
        @(posedge clk_sys);
        #1;
        abort = 1'b0;
        chk("idle_abort_ready", cmd_ready, 1);
        chk("idle_abort_enable", io_enable, 0);
        chk("idle_abort_flag", aborted, 1);

        // reset mid-frame
        new_frame();
        start_frame(8'h63, 4'd1);
        tick(); tick(); tick(); tick();
        chk("f8_pre_enable", io_enable, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("f8_rst_enable", io_enable, 0);
        chk("f8_rst_strobe", io_strobe, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("f8_rst_ready", cmd_ready, 1);
        chk("f8_no_done", ndone, 0);

        new_frame();
        wtab[0] = 16'h1234; resp_d[0] = 16'hE005;
        start_frame(8'h63, 4'd1);
        finish_frame();
        chk("f9_strobes", ns, 2);
        chk("f9_din0", st_din[0], 16'h0063);
        chk("f9_rdata0", rd[0], 16'hE005);
        chk("f9_aborted", aborted_at_done, 0);
        chk("f9_done_cnt", ndone, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
